// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver: 2-flop synchronizer, counter-driven sampling FSM and a
// show-ahead byte FIFO with valid/ready pop plus framing/overrun error pulses.
`timescale 1ns/1ps
module uart_rx_monitor #(
  parameter int CLKS_PER_BIT = 69,
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                              clk_in,
  input  logic                              reset,
  input  logic                              uart_rx,
  output logic [DATA_W-1:0]                 rx_data,
  output logic                              rx_valid,
  input  logic                              rx_ready,
  output logic                              frame_err,
  output logic                              overrun_err,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);
  localparam logic [CW-1:0]    FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  // Synchronizer flops preset to the idle-high line level.
  logic sync1_reg;
  logic sync2_reg;
  logic rxs;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= uart_rx;
      sync2_reg <= sync1_reg;
    end
  end

  assign rxs = sync2_reg;

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [DATA_W-1:0]   shift_reg;
  logic                busy_reg;
  logic                frame_err_reg;
  logic                cnt_zero;

  assign cnt_zero = (cnt_reg == '0);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      shift_reg     <= '0;
      busy_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!rxs) begin
            cnt_reg   <= HALF_LOAD;
            state_reg <= START;
            busy_reg  <= 1'b1;
          end
        end
        START: begin
          if (!cnt_zero) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end else if (rxs) begin
            // Line went back high before mid start bit: treat as a glitch.
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg   <= BIT_LOAD;
            idx_reg   <= '0;
            state_reg <= DATA;
          end
        end
        DATA: begin
          if (!cnt_zero) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end else begin
            shift_reg <= {rxs, shift_reg[DATA_W-1:1]};
            cnt_reg   <= BIT_LOAD;
            if (idx_reg == LAST_IDX) begin
              state_reg <= STOP;
            end else begin
              idx_reg <= idx_reg + IDX_W'(1);
            end
          end
        end
        STOP: begin
          if (!cnt_zero) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end else if (rxs) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            frame_err_reg <= 1'b1;
            state_reg     <= BREAK;
          end
        end
        BREAK: begin
          // Hold here for the whole low period so a break reports one error.
          if (rxs) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_reg;
  assign frame_err = frame_err_reg;

  logic push;
  logic pop;
  logic full;
  logic wr_en;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic              overrun_reg;

  assign push  = (state_reg == STOP) && cnt_zero && rxs;
  assign pop   = rx_valid && rx_ready;
  assign full  = (count_reg == FULL_CNT);
  // A pop in the same cycle frees the slot the push needs.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= shift_reg;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= push && full && !pop;
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rx_valid    = (count_reg != '0);
  assign rx_data     = rx_valid ? mem[rd_ptr_reg] : '0;
  assign fifo_count  = count_reg;
  assign overrun_err = overrun_reg;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor: serial frames driven at 69 clk/bit, a
// negedge monitor logs pops and error pulses, immediate asserts check results.
`timescale 1ns/1ps
module tb_uart_rx_monitor;

  localparam int CPB = 69;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun_err;
  logic [3:0] fifo_count;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] popped[$];
  int fe_cnt = 0;
  int ov_cnt = 0;
  int both_cnt = 0;

  uart_rx_monitor #(.CLKS_PER_BIT(CPB), .DATA_W(8), .FIFO_DEPTH(8)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .uart_rx     (uart_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .fifo_count  (fifo_count),
    .busy        (busy)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (rx_valid && rx_ready) popped.push_back(rx_data);
    if (frame_err) fe_cnt++;
    if (overrun_err) ov_cnt++;
    if (frame_err && overrun_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pop_at(input int i);
    if (i < popped.size()) return 32'(popped[i]);
    return 32'hDEAD;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Drives one 8N1 frame starting 1ns after the next rising edge. With
  // ready_pulse set, rx_ready is high for exactly the stop-sample cycle.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit ready_pulse);
    @(posedge clk_in);
    #1 uart_rx = 1'b0;
    repeat (CPB) @(posedge clk_in);
    for (int i = 0; i < 8; i++) begin
      #1 uart_rx = b[i];
      repeat (CPB) @(posedge clk_in);
    end
    #1 uart_rx = stop_bit;
    if (ready_pulse) begin
      repeat (CPB / 2 + 2) @(posedge clk_in);
      #1 rx_ready = 1'b1;
      @(posedge clk_in);
      #1 rx_ready = 1'b0;
      repeat (CPB - CPB / 2 - 3) @(posedge clk_in);
    end else begin
      repeat (CPB) @(posedge clk_in);
    end
    #1;
    if (stop_bit) uart_rx = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    uart_rx = 1'b1;
    rx_ready = 1'b0;
    wait_cycles(3);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_fifo_count", 32'(fifo_count), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overrun_err", 32'(overrun_err), 32'h0);
    reset = 1'b0;
    wait_cycles(5);

    // 1: single byte with consumer always ready
    rx_ready = 1'b1;
    popped.delete();
    send_byte(8'hA5, 1'b1, 1'b0);
    wait_cycles(10);
    check("t1_pop_count", 32'(popped.size()), 32'd1);
    check("t1_data", pop_at(0), 32'hA5);
    check("t1_frame_err", 32'(fe_cnt), 32'd0);
    check("t1_overrun", 32'(ov_cnt), 32'd0);
    check("t1_fifo_count", 32'(fifo_count), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);

    // 2: fill with consumer stalled, overrun on the ninth byte, then drain
    rx_ready = 1'b0;
    popped.delete();
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1, 1'b0);
    wait_cycles(5);
    check("t2_count_full", 32'(fifo_count), 32'd8);
    check("t2_no_overrun_yet", 32'(ov_cnt), 32'd0);
    check("t2_head_held", 32'(rx_data), 32'h01);
    send_byte(8'h09, 1'b1, 1'b0);
    wait_cycles(5);
    check("t2_overrun_once", 32'(ov_cnt), 32'd1);
    check("t2_count_still_full", 32'(fifo_count), 32'd8);
    check("t2_nothing_popped", 32'(popped.size()), 32'd0);
    rx_ready = 1'b1;
    wait_cycles(20);
    check("t2_pop_count", 32'(popped.size()), 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("t2_pop%0d", i), pop_at(i), 32'(i + 1));
    check("t2_drained", 32'(fifo_count), 32'd0);

    // 3: bad stop bit followed by a long break, then a good byte
    popped.delete();
    fe_cnt = 0;
    send_byte(8'h3C, 1'b0, 1'b0);
    wait_cycles(20 * CPB);
    check("t3_one_frame_err", 32'(fe_cnt), 32'd1);
    check("t3_busy_in_break", 32'(busy), 32'd1);
    uart_rx = 1'b1;
    wait_cycles(5);
    check("t3_busy_released", 32'(busy), 32'd0);
    check("t3_nothing_pushed", 32'(popped.size()), 32'd0);
    check("t3_count", 32'(fifo_count), 32'd0);
    send_byte(8'h55, 1'b1, 1'b0);
    wait_cycles(10);
    check("t3_next_byte", pop_at(0), 32'h55);
    check("t3_frame_err_total", 32'(fe_cnt), 32'd1);

    // 4: short low glitch on an idle line
    popped.delete();
    uart_rx = 1'b0;
    wait_cycles(10);
    check("t4_busy_during_glitch", 32'(busy), 32'd1);
    uart_rx = 1'b1;
    wait_cycles(60);
    check("t4_back_idle", 32'(busy), 32'd0);
    check("t4_no_push", 32'(popped.size()), 32'd0);
    check("t4_no_error", 32'(fe_cnt), 32'd1);

    // 5: reset in the middle of data bit 4 of 0xFF
    popped.delete();
    @(posedge clk_in);
    #1 uart_rx = 1'b0;
    repeat (CPB) @(posedge clk_in);
    #1 uart_rx = 1'b1;
    wait_cycles(4 * CPB + CPB / 2 - 1);
    check("t5_busy_before_reset", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_valid", 32'(rx_valid), 32'd0);
    check("t5_rst_data", 32'(rx_data), 32'd0);
    check("t5_rst_count", 32'(fifo_count), 32'd0);
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(12 * CPB);
    check("t5_no_push", 32'(popped.size()), 32'd0);
    send_byte(8'h81, 1'b1, 1'b0);
    wait_cycles(10);
    check("t5_next_byte", pop_at(0), 32'h81);
    check("t5_pop_count", 32'(popped.size()), 32'd1);

    // 6: full FIFO with a pop landing exactly on the ninth stop-sample cycle
    rx_ready = 1'b0;
    popped.delete();
    ov_cnt = 0;
    for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i), 1'b1, 1'b0);
    send_byte(8'h18, 1'b1, 1'b1);
    wait_cycles(5);
    check("t6_no_overrun", 32'(ov_cnt), 32'd0);
    check("t6_count_full", 32'(fifo_count), 32'd8);
    check("t6_one_pop", 32'(popped.size()), 32'd1);
    rx_ready = 1'b1;
    wait_cycles(20);
    check("t6_pop_count", 32'(popped.size()), 32'd9);
    for (int i = 0; i < 9; i++) check($sformatf("t6_pop%0d", i), pop_at(i), 32'(8'h10 + i));
    check("t6_drained", 32'(fifo_count), 32'd0);
    check("never_both_errors", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
